// File: rtl/cache_fill_fsm.sv
// L1 miss-fill controller: issues one memory read per block word, strobes returns into the data array, writes the tag on the last word.
// Optional macro CACHE_FILL_CWF_EN selects critical-word-first ordering; default build fills sequentially from the block base.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  memory_data_valid,
  output logic                  fsm_busy,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  write_data_array,
  output logic [ADDR_WIDTH-1:0] fill_word_addr,
  output logic                  write_tag_array,
  output logic                  critical_word
);

  localparam int OFS_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W = OFS_W + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] base;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      recv_cnt;
  logic                  in_fill;
  logic                  accept;
  logic                  last_word;

`ifdef CACHE_FILL_CWF_EN
  logic [OFS_W-1:0] offset;
  logic             unused_addr_bit;
  assign unused_addr_bit = miss_address[0];
`else
  logic             unused_addr_bits;
  assign unused_addr_bits = ^miss_address[CNT_W-1:0];
`endif

  // Base has its low bits cleared, so OR-ing in the word byte offset is an add that wraps inside the block.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [CNT_W-1:0] k);
    logic [OFS_W-1:0] idx;
`ifdef CACHE_FILL_CWF_EN
    idx = k[OFS_W-1:0] + offset;
`else
    idx = k[OFS_W-1:0];
`endif
    return base | ADDR_WIDTH'({idx, 1'b0});
  endfunction

  assign in_fill   = (state == FILL);
  assign mem_en    = in_fill && (issue_cnt < CNT_W'(BLOCK_WORDS));
  assign accept    = in_fill && memory_data_valid && (recv_cnt < issue_cnt);
  assign last_word = accept && (recv_cnt == CNT_W'(BLOCK_WORDS - 1));

  assign fsm_busy         = in_fill || miss_detected;
  assign write_data_array = accept;
  assign write_tag_array  = last_word;
  assign memory_address   = in_fill ? word_addr(issue_cnt) : base;
  assign fill_word_addr   = in_fill ? word_addr(recv_cnt) : base;

`ifdef CACHE_FILL_CWF_EN
  assign critical_word = accept && (recv_cnt == '0);
`else
  assign critical_word = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
`ifdef CACHE_FILL_CWF_EN
      offset    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            state     <= FILL;
            base      <= {miss_address[ADDR_WIDTH-1:CNT_W], {CNT_W{1'b0}}};
            issue_cnt <= '0;
            recv_cnt  <= '0;
`ifdef CACHE_FILL_CWF_EN
            offset    <= miss_address[OFS_W:1];
`endif
          end
        end
        FILL: begin
          if (mem_en) issue_cnt <= issue_cnt + CNT_W'(1);
          if (accept) recv_cnt <= recv_cnt + CNT_W'(1);
          // Counters are cleared on the way out so IDLE always looks like the reset state.
          if (last_word) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm (BLOCK_WORDS=8): a fixed-latency memory responder, a list-based fill model
// checked every cycle, and literal expectations for the documented scenarios. Honours CACHE_FILL_CWF_EN.
module tb_cache_fill_fsm;
  localparam int AW = 16;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_detected;
  logic [AW-1:0] miss_address;
  logic          memory_data_valid;
  logic          fsm_busy;
  logic          mem_en;
  logic [AW-1:0] memory_address;
  logic          write_data_array;
  logic [AW-1:0] fill_word_addr;
  logic          write_tag_array;
  logic          critical_word;

  always #5 clk = ~clk;

  cache_fill_fsm #(.ADDR_WIDTH(AW), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .fsm_busy(fsm_busy), .mem_en(mem_en),
    .memory_address(memory_address), .write_data_array(write_data_array),
    .fill_word_addr(fill_word_addr), .write_tag_array(write_tag_array),
    .critical_word(critical_word)
  );

  int errors = 0;
  int checks = 0;

  // Fill model: an open fill is a list of 8 word addresses plus how many have been requested and returned.
  bit          m_fill = 0;
  logic [15:0] m_base = '0;
  int          m_off  = 0;
  int          m_iss  = 0;
  int          m_rcv  = 0;

  // Memory responder and observation logs.
  int          ready_q[$];
  int          cyc  = 0;
  int          lat  = 4;
  bit          gaps = 0;
  bit          spur = 0;
  logic [15:0] req_log[$];
  logic [15:0] wr_log[$];
  int          tag_cnt, cw_cnt, busy_cnt;
  logic [15:0] tag_addr, cw_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] word_of(input int k);
`ifdef CACHE_FILL_CWF_EN
    return m_base + 16'(2 * ((m_off + k) % BW));
`else
    return m_base + 16'(2 * k);
`endif
  endfunction

  task automatic clear_logs();
    req_log.delete(); wr_log.delete();
    tag_cnt = 0; cw_cnt = 0; busy_cnt = 0; tag_addr = '0; cw_addr = '0;
  endtask

  // One clock: compare at the falling edge, advance the model on the rising edge, drive memory 1 time unit later.
  task automatic cycle();
    bit e_busy, e_en, acc, e_cw;
    logic [15:0] e_fa, e_ma;
    @(negedge clk);
    if (!m_fill) begin
      e_busy = miss_detected; e_en = 0; acc = 0; e_fa = m_base; e_ma = m_base;
    end else begin
      e_busy = 1; e_en = (m_iss < BW); acc = memory_data_valid && (m_rcv < m_iss);
      e_fa = word_of(m_rcv); e_ma = word_of(m_iss);
    end
`ifdef CACHE_FILL_CWF_EN
    e_cw = acc && (m_rcv == 0);
`else
    e_cw = 0;
`endif
    check("fsm_busy", fsm_busy, e_busy);
    check("mem_en", mem_en, e_en);
    check("write_data_array", write_data_array, acc);
    check("write_tag_array", write_tag_array, acc && (m_rcv == BW - 1));
    check("critical_word", critical_word, e_cw);
    check("fill_word_addr", fill_word_addr, e_fa);
    if (!m_fill || e_en) check("memory_address", memory_address, e_ma);
    if (mem_en === 1'b1) begin
      req_log.push_back(memory_address);
      ready_q.push_back(cyc + lat - 1);
    end
    if (write_data_array === 1'b1) wr_log.push_back(fill_word_addr);
    if (write_tag_array === 1'b1) begin tag_cnt++; tag_addr = fill_word_addr; end
    if (critical_word === 1'b1) begin cw_cnt++; cw_addr = fill_word_addr; end
    if (fsm_busy === 1'b1) busy_cnt++;
    @(posedge clk);
    if (rst) begin
      m_fill = 0; m_base = '0; m_off = 0; m_iss = 0; m_rcv = 0;
    end else if (!m_fill) begin
      if (miss_detected) begin
        m_fill = 1; m_base = miss_address & 16'hFFF0; m_off = (int'(miss_address) % 16) / 2;
        m_iss = 0; m_rcv = 0;
      end
    end else begin
      if (e_en) m_iss++;
      if (acc) begin
        if (m_rcv == BW - 1) m_fill = 0;
        m_rcv++;
      end
    end
    cyc++;
    #1;
    memory_data_valid = spur;
    spur = 0;
    if (ready_q.size() > 0 && ready_q[0] <= cyc && !(gaps && (cyc % 3) == 0)) begin
      memory_data_valid = 1'b1;
      void'(ready_q.pop_front());
    end
  endtask

  task automatic wait_tag(input string name, input int budget);
    int t0;
    t0 = tag_cnt;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (tag_cnt != t0) return;
    end
    errors++;
    $display("FAIL %s: no tag write within %0d cycles", name, budget);
  endtask

  task automatic start_miss(input logic [15:0] a);
    miss_detected = 1'b1; miss_address = a;
    cycle();
    miss_detected = 1'b0; miss_address = 16'h0;
  endtask

  logic [15:0] exp_seq[8];

  initial begin
    rst = 1'b1; miss_detected = 1'b0; miss_address = '0; memory_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;
    // Reset-state literals.
    check("rst_mem_en", mem_en, 0);
    check("rst_memory_address", memory_address, 16'h0);
    check("rst_fill_word_addr", fill_word_addr, 16'h0);
    check("rst_busy_idle", fsm_busy, 0);
    miss_address = 16'h1236; #1;
    check("rst_busy_follows_miss", fsm_busy, 0);
    miss_detected = 1'b1; #1;
    check("rst_busy_follows_miss_hi", fsm_busy, 1);
    miss_detected = 1'b0; miss_address = '0;
    cycle();

    // Miss at 0x1236, latency 4, no gaps.
`ifdef CACHE_FILL_CWF_EN
    exp_seq = '{16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232, 16'h1234};
`else
    exp_seq = '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E};
`endif
    clear_logs(); lat = 4; gaps = 0;
    start_miss(16'h1236);
    wait_tag("fill1_done", 60);
    repeat (3) cycle();
    check("fill1_req_count", req_log.size(), 8);
    check("fill1_wr_count", wr_log.size(), 8);
    for (int k = 0; k < 8 && k < req_log.size() && k < wr_log.size(); k++) begin
      check($sformatf("fill1_req%0d", k), req_log[k], exp_seq[k]);
      check($sformatf("fill1_wr%0d", k), wr_log[k], exp_seq[k]);
    end
    check("fill1_tag_count", tag_cnt, 1);
    check("fill1_tag_addr", tag_addr, exp_seq[7]);
    check("fill1_busy_cycles", busy_cnt, 12);
`ifdef CACHE_FILL_CWF_EN
    check("fill1_cw_count", cw_cnt, 1);
    check("fill1_cw_addr", cw_addr, 16'h1236);
`else
    check("fill1_cw_count", cw_cnt, 0);
`endif

    // Spurious valids in IDLE after the fill.
    clear_logs();
    spur = 1; cycle();
    check("spur_valid_seen", memory_data_valid, 1);
    spur = 1; cycle(); cycle(); cycle();
    check("spur_wr_count", wr_log.size(), 0);
    check("spur_busy", busy_cnt, 0);

    // Memory with gaps.
    clear_logs(); lat = 3; gaps = 1;
    start_miss(16'h2A58);
    wait_tag("gaps_done", 80);
    repeat (3) cycle();
    check("gaps_req_count", req_log.size(), 8);
    check("gaps_wr_count", wr_log.size(), 8);
    check("gaps_tag_count", tag_cnt, 1);
    check("gaps_first_req", req_log.size() > 0 ? req_log[0] : 16'hFFFF, 16'h2A58 & 16'hFFF0 | (`ifdef CACHE_FILL_CWF_EN 16'h8 `else 16'h0 `endif));

    // Reset after three returned words.
    clear_logs(); lat = 4; gaps = 0;
    start_miss(16'h1236);
    for (int i = 0; i < 40 && wr_log.size() < 3; i++) cycle();
    check("rstmid_three_words", wr_log.size(), 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rstmid_mem_en", mem_en, 0);
    check("rstmid_wr", write_data_array, 0);
    check("rstmid_memory_address", memory_address, 16'h0);
    check("rstmid_fill_word_addr", fill_word_addr, 16'h0);
    check("rstmid_busy", fsm_busy, 0);
    repeat (12) cycle();
    check("rstmid_late_dropped", wr_log.size(), 4);
    check("rstmid_no_tag", tag_cnt, 0);
    clear_logs();
    start_miss(16'h0100);
    wait_tag("rstmid_refill_done", 60);
    repeat (3) cycle();
    check("refill_wr_count", wr_log.size(), 8);
    check("refill_tag_count", tag_cnt, 1);

    // Back-to-back: second miss held high during the first fill.
    clear_logs();
    miss_detected = 1'b1; miss_address = 16'h1236;
    cycle();
    miss_address = 16'h4000;
    wait_tag("b2b_first_done", 60);
    check("b2b_first_req_count", req_log.size(), 8);
    check("b2b_idle_busy", fsm_busy, 1);
    check("b2b_idle_mem_en", mem_en, 0);
    cycle();
    miss_detected = 1'b0; miss_address = '0;
    check("b2b_second_mem_en", mem_en, 1);
    check("b2b_second_addr", memory_address, 16'h4000);
    wait_tag("b2b_second_done", 60);
    repeat (3) cycle();
    check("b2b_total_wr", wr_log.size(), 16);
    check("b2b_total_tag", tag_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
